// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard controller of the 5-stage ARM core.
package hazard_pkg;

  localparam int AW_DEF     = 4;
  localparam int PC_REG_DEF = 15;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_mc_sequencer.sv
// Multi-cycle execute sequencer: keeps a MUL/MLA in Execute for MC_CYCLES cycles.
// The stall is raised on the start cycle and every busy cycle except the last,
// so the op advances out of Execute on its final cycle.
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic stall
);

  localparam int CW = $clog2(MC_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MC_CYCLES - 2);

  mc_state_e     state_q;
  logic [CW-1:0] cnt_q;

  // Sequencer FSM and countdown; start is ignored while busy so the held op cannot retrigger.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= BUSY;
            cnt_q   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy  = (state_q == BUSY);
  assign stall = ((state_q == IDLE) && start) || ((state_q == BUSY) && (cnt_q != '0));

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipelined ARM core: operand forwarding,
// load-use stall, branch flush and multi-cycle execute stall.
// Optional macro HAZARD_PERF_EN adds saturating StallCnt/FlushCnt counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int NREAD     = 2,
  parameter int PC_REG    = PC_REG_DEF,
  parameter int MC_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   RAD,
  input  logic [NREAD*AW-1:0]   RAE,
  input  logic [AW-1:0]         WA3E,
  input  logic [AW-1:0]         WA3M,
  input  logic [AW-1:0]         WA3W,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MultiCycleE,
  input  logic                  BranchTakenE,
  output logic [NREAD*2-1:0]    ForwardE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           StallCnt,
  output logic [31:0]           FlushCnt,
`endif
  output logic                  McBusy
);

  localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

  logic [NREAD*2-1:0] fwdSel;
  logic               ldStall;
  logic               mcStall;
  logic               mcBusy;
  fwd_sel_e           portSel;

  mc_sequencer #(.MC_CYCLES(MC_CYCLES)) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (MultiCycleE),
    .busy  (mcBusy),
    .stall (mcStall)
  );

  // Per-port forwarding select; the newer M result wins over W, and the PC is never forwarded.
  always_comb begin
    fwdSel  = '0;
    portSel = FWD_RF;
    for (int i = 0; i < NREAD; i++) begin
      portSel = FWD_RF;
      if (RAE[i*AW +: AW] != PC_ADDR) begin
        if (RegWriteM && (RAE[i*AW +: AW] == WA3M)) begin
          portSel = FWD_M;
        end else if (RegWriteW && (RAE[i*AW +: AW] == WA3W)) begin
          portSel = FWD_W;
        end
      end
      fwdSel[i*2 +: 2] = portSel;
    end
  end

  // Load-use detection: a Decode source needs the load currently in Execute.
  always_comb begin
    ldStall = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      if ((RAD[i*AW +: AW] == WA3E) && (RAD[i*AW +: AW] != PC_ADDR)) begin
        ldStall = 1'b1;
      end
    end
    ldStall = ldStall & MemtoRegE & RegWriteE;
  end

  // Priority combine: the sequencer dominates, a taken branch overrides load-use, reset silences all.
  always_comb begin
    ForwardE = '0;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    McBusy   = 1'b0;
    if (!reset) begin
      ForwardE = fwdSel;
      StallF   = mcStall | (ldStall & ~BranchTakenE);
      StallD   = mcStall | (ldStall & ~BranchTakenE);
      StallE   = mcStall;
      FlushM   = mcStall;
      FlushE   = ~mcStall & (ldStall | BranchTakenE);
      FlushD   = ~mcStall & BranchTakenE;
      McBusy   = mcBusy;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt_q, stallCnt_d;
  logic [31:0] flushCnt_q, flushCnt_d;

  // Next value of the saturating stall/flush event counters.
  always_comb begin
    stallCnt_d = stallCnt_q;
    flushCnt_d = flushCnt_q;
    if (StallF && (stallCnt_q != '1)) stallCnt_d = stallCnt_q + 32'd1;
    if (FlushE && (flushCnt_q != '1)) flushCnt_d = flushCnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
      flushCnt_q <= flushCnt_d;
    end
  end

  assign StallCnt = stallCnt_q;
  assign FlushCnt = flushCnt_q;
`endif

endmodule
